// File: rtl/led_ctrl_if.sv
// rtl/led_ctrl_if.sv - register bus between a bus master and the LED controller
interface led_ctrl_if;
  logic [1:0]  Addr;
  logic [31:0] Din;
  logic        We;
  logic [31:0] Dout;

  modport master (output Addr, output Din, output We, input Dout);
  modport slave  (input Addr, input Din, input We, output Dout);
endinterface

// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - memory-mapped LED controller with static, blink, rotate and PWM modes
module led_ctrl #(
  parameter int                    N_LED       = 16,
  parameter logic [31:0]           RST_PATTERN = 32'h000055aa,
  parameter int                    CNT_W       = 24,
  parameter logic [CNT_W-1:0]      DEF_PERIOD  = 24'd49999,
  parameter int                    PWM_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  led_ctrl_if.slave        bus,
  output logic [N_LED-1:0] user_led
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_PWM    = 2'b11
  } mode_t;

  localparam logic [N_LED-1:0] RST_LED  = RST_PATTERN[N_LED-1:0];
  localparam logic [PWM_W-1:0] DUTY_RST = PWM_W'(1) << (PWM_W - 1);

  logic [N_LED-1:0] pattern;
  logic [N_LED-1:0] sh;
  logic [N_LED-1:0] display;
  logic [2:0]       ctrl;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] pwm_cnt;
  logic             phase;
  logic             wr_pat, wr_ctrl, wr_period, wr_duty;
  logic             tick;
  mode_t            mode;
  logic             unused_din;

  assign unused_din = &{1'b0, bus.Din};

  assign wr_pat    = bus.We && (bus.Addr == 2'd0);
  assign wr_ctrl   = bus.We && (bus.Addr == 2'd1);
  assign wr_period = bus.We && (bus.Addr == 2'd2);
  assign wr_duty   = bus.We && (bus.Addr == 2'd3);

  // A CTRL or PERIOD write restarts the prescaler and swallows any tick due that cycle.
  assign tick = (cnt == period) && !(wr_ctrl || wr_period);
  assign mode = mode_t'(ctrl[1:0]);

  function automatic logic [N_LED-1:0] rot_left(input logic [N_LED-1:0] v);
    return (v << 1) | (v >> (N_LED - 1));
  endfunction

  function automatic logic [N_LED-1:0] rot_right(input logic [N_LED-1:0] v);
    return (v >> 1) | (v << (N_LED - 1));
  endfunction

  always_comb begin
    display = pattern;
    case (mode)
      MODE_STATIC: display = pattern;
      MODE_BLINK:  display = phase ? pattern : '0;
      MODE_ROTATE: display = sh;
      MODE_PWM:    display = (pwm_cnt < duty) ? pattern : '0;
      default:     display = pattern;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern  <= RST_LED;
      ctrl     <= 3'd0;
      period   <= DEF_PERIOD;
      duty     <= DUTY_RST;
      cnt      <= '0;
      pwm_cnt  <= '0;
      phase    <= 1'b1;
      sh       <= RST_LED;
      user_led <= RST_LED;
    end else begin
      user_led <= display;
      pwm_cnt  <= pwm_cnt + PWM_W'(1);

      if (wr_pat)    pattern <= bus.Din[N_LED-1:0];
      if (wr_ctrl)   ctrl    <= bus.Din[2:0];
      if (wr_period) period  <= bus.Din[CNT_W-1:0];
      if (wr_duty)   duty    <= bus.Din[PWM_W-1:0];

      if (wr_ctrl || wr_period || tick) cnt <= '0;
      else                              cnt <= cnt + CNT_W'(1);

      if (wr_ctrl)   phase <= 1'b1;
      else if (tick) phase <= ~phase;

      // A new pattern beats a same-cycle rotation step.
      if (wr_pat)       sh <= bus.Din[N_LED-1:0];
      else if (wr_ctrl) sh <= pattern;
      else if (tick)    sh <= ctrl[2] ? rot_right(sh) : rot_left(sh);
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (bus.Addr)
      2'd0:    bus.Dout[N_LED-1:0] = pattern;
      2'd1:    bus.Dout[2:0]       = ctrl;
      2'd2:    bus.Dout[CNT_W-1:0] = period;
      2'd3:    bus.Dout[PWM_W-1:0] = duty;
      default: bus.Dout = '0;
    endcase
  end

endmodule

// File: doc/led_ctrl.md
# led_ctrl

Parametrised memory-mapped LED controller on the device bus. It drives N_LED user LEDs from a software-written pattern register in one of four modes: static, blink, rotate, or PWM dim. A shared prescaler sets the blink and rotate rate. It extends the single-register LED device with a register file, a readback path, and time-based display modes.

## Interface
- N_LED, 16, number of LEDs (1..32)
- RST_PATTERN, 32'h000055aa, reset pattern; low N_LED bits used
- CNT_W, 24, prescaler/PERIOD width
- DEF_PERIOD, 24'd49999, PERIOD reset value
- PWM_W, 8, PWM counter/DUTY width
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- Addr  input  2  register select: 0 PATTERN, 1 CTRL, 2 PERIOD, 3 DUTY
- Din  input  32  write data
- We  input  1  write enable, sampled on posedge clk
- Dout  output  32  combinational readback of register at Addr; unused upper bits 0
- user_led  output  N_LED  registered LED drive

## Operation
- PATTERN (Addr 0): N_LED bits, reset RST_PATTERN[N_LED-1:0].
- CTRL (Addr 1): [1:0] mode (00 static, 01 blink, 10 rotate, 11 PWM); [2] dir (0 rotate left toward MSB, 1 right). Reset 0.
- PERIOD (Addr 2): CNT_W bits, reset DEF_PERIOD.
- DUTY (Addr 3): PWM_W bits, reset 2^(PWM_W-1).
- Writes take Din low bits; excess bits are ignored.
- Prescaler cnt (CNT_W):
  - Counts 0..PERIOD.
  - tick = (cnt==PERIOD); cnt wraps to 0 on tick, so one tick every PERIOD+1 cycles. PERIOD=0 gives a tick every cycle.
  - cnt clears to 0 on any write to PERIOD or CTRL. A tick in that same cycle is suppressed.
- Blink:
  - Phase bit, reset 1, toggles on tick.
  - Display = phase ? PATTERN : 0.
  - A CTRL write sets phase to 1. A PATTERN write does not affect phase.
- Rotate:
  - Working register sh (N_LED), reset RST_PATTERN.
  - On tick, sh rotates by 1 in direction dir, with wrap-around between MSB and LSB.
  - A PATTERN write loads sh = Din; this write wins over a same-cycle tick.
  - A CTRL write reloads sh = PATTERN.
  - Display = sh.
- PWM:
  - pwm_cnt (PWM_W) free-runs every cycle from 0 and wraps at 2^PWM_W-1→0. It is not tied to the prescaler.
  - Display = PATTERN when pwm_cnt < DUTY, else 0.
  - DUTY=0 gives always dark; DUTY=2^PWM_W-1 gives dark 1 cycle per 2^PWM_W.
- Static: display = PATTERN.
- cnt, phase, sh and pwm_cnt run in every mode. Only the selected mode drives the display.
- Dout: Addr 0 returns PATTERN (not sh), 1 CTRL, 2 PERIOD, 3 DUTY. Dout is zero-extended.

## Timing
- Reset (rst high at an edge) sets:
  - user_led = RST_PATTERN[N_LED-1:0]
  - cnt = 0, pwm_cnt = 0, phase = 1, sh = RST_PATTERN
  - all registers to their reset values
- rst overrides We, including mid-blink, mid-rotate or mid-PWM.
- user_led <= display(state before the edge), so it lags internal state by one cycle.
- A PATTERN write sampled at edge k appears on user_led after edge k+1 (static mode).
- A mode change written at edge k takes effect on user_led at edge k+1.
- Dout follows Addr and register contents with no cycle delay. A register written at edge k reads new data immediately after edge k.
- One write per cycle; no back-pressure; We is always accepted.

## Test plan
- Reset: assert rst 2 cycles with We=1, Din=0 -> user_led=16'h55aa, Dout@1=0, Dout@2=DEF_PERIOD, Dout@3=8'h80.
- Static: write PATTERN=32'h1234_A5F0 at edge k -> user_led=16'hA5F0 after edge k+1; Dout@0=16'hA5F0.
- Blink: PERIOD=3, CTRL=1, PATTERN=16'h00FF -> user_led alternates 00FF/0000 every 4 cycles, starting with 00FF.
- Rotate: PATTERN=16'h8001, PERIOD=0, CTRL=2 -> user_led sequence 8001, 0003, 0006, …. CTRL=6 -> sequence from 8001: C000, 6000, ….
- Rotate collision: PATTERN write 16'h0F00 on a tick cycle -> sh=0F00 unrotated; the rotation resumes on the next tick.
- PWM: PATTERN=16'hFFFF, CTRL=3, DUTY=64 -> over 256 cycles user_led=FFFF for exactly 64 cycles. DUTY=0 -> always 0. Mid-run rst -> 55aa on the next cycle.
